// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter: shares one AR/R port between fetch (M0) and load (M1).
// Optional macro ARB_RR_EN selects round-robin tie-break; default is fixed priority with M1 winning.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic [2:0]        m0_arcache,
  output logic              m0_arready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rlast,
  input  logic              m0_rready,

  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic [2:0]        m1_arcache,
  output logic              m1_arready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rlast,
  input  logic              m1_rready,

  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic [2:0]        s_arcache,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rlast,
  output logic              s_rready,

  output logic              busy,
  output logic              grant_id,
  output logic              burst_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic              r_sArvalid;
  logic [ADDR_W-1:0] r_sAraddr;
  logic [7:0]        r_sArlen;
  logic [2:0]        r_sArsize;
  logic [1:0]        r_sArburst;
  logic [2:0]        r_sArcache;
  logic              r_grantId;
  logic              r_burstErr;
  logic [8:0]        r_beatCnt;

  logic              w_anyReq;
  logic              w_winner;
  logic              w_grant;
  logic              w_rready;
  logic              w_beat;
  logic              w_beatErr;

  assign w_anyReq = m0_arvalid | m1_arvalid;
  assign w_grant  = (r_state == IDLE) && w_anyReq;

`ifdef ARB_RR_EN
  // Pointer names the master that wins the next simultaneous request.
  logic r_rrPtr;

  assign w_winner = (m0_arvalid && m1_arvalid) ? r_rrPtr : m1_arvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrPtr <= 1'b0;
    end else if (w_grant) begin
      r_rrPtr <= ~w_winner;
    end
  end
`else
  assign w_winner = m1_arvalid;
`endif

  assign w_rready  = r_grantId ? m1_rready : m0_rready;
  assign w_beatErr = s_rlast ? (r_beatCnt != {1'b0, r_sArlen})
                             : (r_beatCnt == {1'b0, r_sArlen});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    m0_arready  = 1'b0;
    m1_arready  = 1'b0;
    s_rready    = 1'b0;
    m0_rvalid   = 1'b0;
    m0_rdata    = '0;
    m0_rlast    = 1'b0;
    m1_rvalid   = 1'b0;
    m1_rdata    = '0;
    m1_rlast    = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          m0_arready  = ~w_winner;
          m1_arready  = w_winner;
          w_nextState = ADDR;
        end
      end
      ADDR: begin
        if (s_arready) begin
          w_nextState = DATA;
        end
      end
      DATA: begin
        s_rready = w_rready;
        w_beat   = s_rvalid & w_rready;
        if (r_grantId) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rlast  = s_rlast;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rlast  = s_rlast;
        end
        // No arbitration in the last-beat cycle; the next grant waits for IDLE.
        if (w_beat && s_rlast) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sArvalid <= 1'b0;
      r_sAraddr  <= '0;
      r_sArlen   <= '0;
      r_sArsize  <= '0;
      r_sArburst <= '0;
      r_sArcache <= '0;
      r_grantId  <= 1'b0;
      r_burstErr <= 1'b0;
      r_beatCnt  <= '0;
    end else begin
      if (w_grant) begin
        r_sArvalid <= 1'b1;
        r_sAraddr  <= w_winner ? m1_araddr  : m0_araddr;
        r_sArlen   <= w_winner ? m1_arlen   : m0_arlen;
        r_sArsize  <= w_winner ? m1_arsize  : m0_arsize;
        r_sArburst <= w_winner ? m1_arburst : m0_arburst;
        r_sArcache <= w_winner ? m1_arcache : m0_arcache;
        r_grantId  <= w_winner;
        r_beatCnt  <= '0;
      end else if ((r_state == ADDR) && s_arready) begin
        r_sArvalid <= 1'b0;
      end
      if (w_beat) begin
        r_beatCnt <= r_beatCnt + 9'd1;
        if (w_beatErr) begin
          r_burstErr <= 1'b1;
        end
      end
    end
  end

  assign s_arvalid = r_sArvalid;
  assign s_araddr  = r_sAraddr;
  assign s_arlen   = r_sArlen;
  assign s_arsize  = r_sArsize;
  assign s_arburst = r_sArburst;
  assign s_arcache = r_sArcache;
  assign busy      = (r_state != IDLE);
  assign grant_id  = r_grantId;
  assign burst_err = r_burstErr;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: vector table of transactions plus hand-written corner sequences.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize, m0_arcache;
  logic [1:0]  m0_arburst;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize, m1_arcache;
  logic [1:0]  m1_arburst;
  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize, s_arcache;
  logic [1:0]  s_arburst;
  logic        busy, grant_id, burst_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          m0Req;
    bit          m1Req;
    logic [31:0] m0Addr;
    logic [31:0] m1Addr;
    logic [7:0]  m0Len;
    logic [7:0]  m1Len;
    int          arDelay;
    int          stallBeat;
    bit          expFixed;
    bit          expRr;
    logic [31:0] seed;
  } vec_t;

  typedef struct {
    bit          master;
    logic [31:0] data;
    bit          last;
  } beat_t;

  vec_t  vecs[6];
  beat_t sbq[$];

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arcache(m0_arcache), .m0_arready(m0_arready), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arcache(m1_arcache), .m1_arready(m1_arready), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arcache(s_arcache), .s_arready(s_arready), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rready(s_rready),
    .busy(busy), .grant_id(grant_id), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setRready(input bit g, input bit v);
    if (g) begin
      m1_rready = v;
      m0_rready = ~v;
    end else begin
      m0_rready = v;
      m1_rready = ~v;
    end
  endtask

  task automatic setReq(input bit g, input logic [31:0] addr, input logic [7:0] len);
    if (g) begin
      m1_araddr  = addr;
      m1_arlen   = len;
      m1_arvalid = 1'b1;
    end else begin
      m0_araddr  = addr;
      m0_arlen   = len;
      m0_arvalid = 1'b1;
    end
  endtask

  // Starts #1 after a rising edge in IDLE with master g requesting; ends #1 after its final beat edge.
  task automatic runTxn(input bit g, input logic [31:0] addr, input logic [7:0] len, input int arDelay,
                        input int stallBeat, input logic [31:0] seed, input int lastAt);
    logic [31:0] data;
    beat_t       e;
    @(negedge clk);
    checkOutput("arready_winner", g ? m1_arready : m0_arready, 1);
    checkOutput("arready_loser", g ? m0_arready : m1_arready, 0);
    checkOutput("busy_idle", busy, 0);
    @(posedge clk); #1;
    if (g) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
    @(negedge clk);
    checkOutput("s_arvalid", s_arvalid, 1);
    checkOutput("s_araddr", s_araddr, addr);
    checkOutput("s_arlen", s_arlen, len);
    checkOutput("s_arsize", s_arsize, g ? 3'd3 : 3'd2);
    checkOutput("s_arburst", s_arburst, g ? 2'b10 : 2'b01);
    checkOutput("s_arcache", s_arcache, g ? 3'b101 : 3'b011);
    checkOutput("grant_id", grant_id, g);
    checkOutput("busy_addr", busy, 1);
    checkOutput("arready_addr", {m1_arready, m0_arready}, 0);
    for (int d = 0; d < arDelay; d++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("s_arvalid_hold", s_arvalid, 1);
      checkOutput("s_araddr_hold", s_araddr, addr);
    end
    s_arready = 1'b1;
    @(posedge clk); #1;
    s_arready = 1'b0;
    @(negedge clk);
    checkOutput("s_arvalid_done", s_arvalid, 0);
    checkOutput("busy_data", busy, 1);
    for (int b = 0; b <= lastAt; b++) begin
      data = seed + 32'(b) * 32'h01010101;
      if (b == stallBeat) begin
        s_rvalid = 1'b1;
        s_rdata  = data;
        s_rlast  = (b == lastAt);
        setRready(g, 1'b0);
        #1;
        checkOutput("s_rready_stall", s_rready, 0);
        checkOutput("rvalid_stall", g ? m1_rvalid : m0_rvalid, 1);
        @(posedge clk); #1;
        @(negedge clk);
      end
      s_rvalid = 1'b1;
      s_rdata  = data;
      s_rlast  = (b == lastAt);
      setRready(g, 1'b1);
      sbq.push_back('{g, data, (b == lastAt)});
      #1;
      e = sbq.pop_front();
      checkOutput("rvalid", e.master ? m1_rvalid : m0_rvalid, 1);
      checkOutput("rdata", e.master ? m1_rdata : m0_rdata, e.data);
      checkOutput("rlast", e.master ? m1_rlast : m0_rlast, e.last);
      checkOutput("other_rvalid", e.master ? m0_rvalid : m1_rvalid, 0);
      checkOutput("other_rdata", e.master ? m0_rdata : m1_rdata, 0);
      checkOutput("s_rready", s_rready, 1);
      checkOutput("arready_data", {m1_arready, m0_arready}, 0);
      @(posedge clk); #1;
      if (b < lastAt) @(negedge clk);
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    s_rdata  = '0;
    m0_rready = 1'b0;
    m1_rready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bit first;
`ifdef ARB_RR_EN
    first = v.expRr;
`else
    first = v.expFixed;
`endif
    m0_araddr  = v.m0Addr;
    m0_arlen   = v.m0Len;
    m1_araddr  = v.m1Addr;
    m1_arlen   = v.m1Len;
    m0_arvalid = v.m0Req;
    m1_arvalid = v.m1Req;
    if (first) runTxn(1'b1, v.m1Addr, v.m1Len, v.arDelay, v.stallBeat, v.seed, int'(v.m1Len));
    else       runTxn(1'b0, v.m0Addr, v.m0Len, v.arDelay, v.stallBeat, v.seed, int'(v.m0Len));
    if (v.m0Req && v.m1Req) begin
      if (first) runTxn(1'b0, v.m0Addr, v.m0Len, v.arDelay, v.stallBeat, v.seed ^ 32'h5555_0000, int'(v.m0Len));
      else       runTxn(1'b1, v.m1Addr, v.m1Len, v.arDelay, v.stallBeat, v.seed ^ 32'h5555_0000, int'(v.m1Len));
    end
  endtask

  initial begin
    // m0Req, m1Req, m0Addr, m1Addr, m0Len, m1Len, arDelay, stallBeat, expFixed, expRr, seed
    vecs[0] = '{1'b1, 1'b1, 32'h200,  32'h100, 8'd1, 8'd3, 0, -1, 1'b1, 1'b0, 32'h1111_0000};
    vecs[1] = '{1'b1, 1'b0, 32'h240,  32'h0,   8'd0, 8'd0, 1, -1, 1'b0, 1'b0, 32'h2222_0000};
    vecs[2] = '{1'b1, 1'b1, 32'h200,  32'h100, 8'd1, 8'd3, 0, -1, 1'b1, 1'b1, 32'h3333_0000};
    vecs[3] = '{1'b1, 1'b0, 32'h40,   32'h0,   8'd0, 8'd0, 0, -1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b1, 32'h0,    32'h180, 8'd0, 8'd2, 5,  1, 1'b1, 1'b1, 32'hA5A5_0000};
    vecs[5] = '{1'b1, 1'b0, 32'h1000, 32'h0,   8'd7, 8'd0, 2,  0, 1'b0, 1'b0, 32'h0102_0304};

    rst = 1'b1;
    m0_arvalid = 1'b0; m0_araddr = '0; m0_arlen = '0; m0_rready = 1'b0;
    m1_arvalid = 1'b0; m1_araddr = '0; m1_arlen = '0; m1_rready = 1'b0;
    m0_arsize = 3'd2; m0_arburst = 2'b01; m0_arcache = 3'b011;
    m1_arsize = 3'd3; m1_arburst = 2'b10; m1_arcache = 3'b101;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_burst_err", burst_err, 0);
    checkOutput("rst_s_arvalid", s_arvalid, 0);
    checkOutput("rst_s_araddr", s_araddr, 0);
    checkOutput("rst_s_arlen", s_arlen, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end
    @(negedge clk);
    checkOutput("burst_err_clean", burst_err, 0);
    @(posedge clk); #1;

    $display("[TB] early rlast sequence");
    setReq(1'b0, 32'h280, 8'd3);
    runTxn(1'b0, 32'h280, 8'd3, 0, -1, 32'h7777_0000, 1);
    @(negedge clk);
    checkOutput("early_rlast_idle", busy, 0);
    checkOutput("early_rlast_err", burst_err, 1);
    @(posedge clk); #1;
    setReq(1'b1, 32'h2C0, 8'd0);
    runTxn(1'b1, 32'h2C0, 8'd0, 0, -1, 32'h8888_0000, 0);
    @(negedge clk);
    checkOutput("burst_err_sticky", burst_err, 1);
    @(posedge clk); #1;

    $display("[TB] reset during data sequence");
    setReq(1'b0, 32'h300, 8'd3);
    @(posedge clk); #1;
    m0_arvalid = 1'b0;
    s_arready  = 1'b1;
    @(posedge clk); #1;
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = 32'hCAFE_0000;
    s_rlast   = 1'b0;
    setRready(1'b0, 1'b1);
    @(posedge clk); #1;
    s_rdata = 32'hCAFE_0001;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_s_arvalid", s_arvalid, 0);
    checkOutput("abort_burst_err", burst_err, 0);
    checkOutput("abort_m0_rvalid", m0_rvalid, 0);
    checkOutput("abort_m1_rvalid", m1_rvalid, 0);
    rst = 1'b0;
    s_rvalid = 1'b0;
    s_rdata  = '0;
    m0_rready = 1'b0;
    m1_rready = 1'b0;
    @(posedge clk); #1;

    $display("[TB] missing rlast sequence");
    setReq(1'b1, 32'h340, 8'd1);
    runTxn(1'b1, 32'h340, 8'd1, 0, -1, 32'h9999_0000, 2);
    @(negedge clk);
    checkOutput("missing_rlast_err", burst_err, 1);
    checkOutput("missing_rlast_grant", grant_id, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("final_rst_err", burst_err, 0);
    checkOutput("final_rst_grant", grant_id, 0);
    checkOutput("final_rst_araddr", s_araddr, 0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
